// File: rtl/tx_wrr_sched_pkg.sv
// Shared types and helpers for the CCI-P Tx weighted round-robin scheduler.
// Latency: n/a (types, constants and a pure combinational pick function).
// Backpressure: n/a.
package tx_sched_pkg;

    localparam int STAT_W = 32;
    // Upper bound on requester count supported by rr_pick.
    localparam int MAX_N  = 32;

    typedef enum logic {
        C1_IDLE  = 1'b0,
        C1_BURST = 1'b1
    } t_c1_state;

    // First set request searching from ptr+1 with wrap; ptr itself is checked last.
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input int unsigned       ptr,
                                                 input int unsigned       n);
        logic [MAX_N-1:0] gnt;
        int unsigned      idx;
        gnt = '0;
        for (int unsigned k = 1; k <= MAX_N; k++) begin
            if (k <= n && gnt == '0) begin
                idx = (ptr + k) % n;
                if (req[idx[4:0]]) gnt[idx[4:0]] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/tx_wrr_sched_if.sv
// Request/grant/config bundle between the sub-AFU side and tx_wrr_sched.
// Latency: n/a (wires only).
// Backpressure: n/a; optional stat port present when TX_SCHED_STATS_EN is defined.
interface tx_wrr_sched_if
    import tx_sched_pkg::*;
#(
    parameter int N_SUBAFUS = 3,
    parameter int WEIGHT_W  = 4
);
    localparam int IDX_W = $clog2(N_SUBAFUS);

    logic [N_SUBAFUS-1:0] req_c0;
    logic [N_SUBAFUS-1:0] req_c1;
    logic [N_SUBAFUS-1:0] req_c1_sop;
    logic [N_SUBAFUS-1:0] req_c1_eop;
    logic                 in_c0_almFull;
    logic                 in_c1_almFull;
    logic                 cfg_wr_en;
    logic [IDX_W-1:0]     cfg_idx;
    logic [WEIGHT_W-1:0]  cfg_weight;
    logic [N_SUBAFUS-1:0] grant_c0;
    logic [N_SUBAFUS-1:0] grant_c1;
    logic                 c1_burst_active;
`ifdef TX_SCHED_STATS_EN
    logic [IDX_W-1:0]     stat_idx;
    logic [STAT_W-1:0]    stat_c0_cnt;
    logic [STAT_W-1:0]    stat_c1_cnt;
`endif

    modport master (
        output req_c0, req_c1, req_c1_sop, req_c1_eop,
        output in_c0_almFull, in_c1_almFull,
        output cfg_wr_en, cfg_idx, cfg_weight,
        input  grant_c0, grant_c1, c1_burst_active
`ifdef TX_SCHED_STATS_EN
        , output stat_idx
        , input  stat_c0_cnt, stat_c1_cnt
`endif
    );

    modport slave (
        input  req_c0, req_c1, req_c1_sop, req_c1_eop,
        input  in_c0_almFull, in_c1_almFull,
        input  cfg_wr_en, cfg_idx, cfg_weight,
        output grant_c0, grant_c1, c1_burst_active
`ifdef TX_SCHED_STATS_EN
        , input  stat_idx
        , output stat_c0_cnt, stat_c1_cnt
`endif
    );

endinterface

// File: rtl/tx_wrr_chan.sv
// One channel of weighted round-robin: pointer, credit window and next-grant pick.
// Latency: combinational next grant; caller registers it (grant at t+1).
// Backpressure: i_hold suppresses the grant and freezes pointer and credit.
module tx_wrr_chan
    import tx_sched_pkg::*;
#(
    parameter int N        = 3,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          i_req,
    input  logic                  i_hold,
    input  logic [N*WEIGHT_W-1:0] i_weights,
    output logic [N-1:0]          o_grant,
    output logic [IDX_W-1:0]      o_idx
);

    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt, w_pick_idx;
    logic [WEIGHT_W-1:0] r_credit, w_credit_nxt, w_load;
    // Until the first pick the search starts at requester 0 rather than ptr+1.
    logic                r_started, w_started_nxt;
    logic [N-1:0]        w_pick, w_cur;
    logic [MAX_N-1:0]    w_req_full, w_pick_full;

    // Round-robin candidate and its credit load (weight 0 behaves as 1).
    always_comb begin
        w_req_full         = '0;
        w_req_full[N-1:0]  = i_req;
        w_pick_full        = rr_pick(w_req_full, r_started ? 32'(r_ptr) : 32'(N - 1), 32'(N));
        w_pick             = w_pick_full[N-1:0];
        w_pick_idx         = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) w_pick_idx = IDX_W'(i);
        end
        w_load = i_weights[w_pick_idx*WEIGHT_W +: WEIGHT_W];
        if (w_load != '0) w_load = w_load - WEIGHT_W'(1);
        w_cur        = '0;
        w_cur[r_ptr] = 1'b1;
    end

    // Keep the current owner while it has credit, else pick; clear credit when idle.
    always_comb begin
        o_grant       = '0;
        w_ptr_nxt     = r_ptr;
        w_credit_nxt  = r_credit;
        w_started_nxt = r_started;
        if (!i_hold) begin
            if (r_started && r_credit != '0 && i_req[r_ptr]) begin
                o_grant      = w_cur;
                w_credit_nxt = r_credit - WEIGHT_W'(1);
            end else if (|i_req) begin
                o_grant       = w_pick;
                w_ptr_nxt     = w_pick_idx;
                w_credit_nxt  = w_load;
                w_started_nxt = 1'b1;
            end else begin
                w_credit_nxt = '0;
            end
        end
        o_idx = w_ptr_nxt;
    end

    // Pointer and credit state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_credit  <= '0;
            r_started <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_credit  <= w_credit_nxt;
            r_started <= w_started_nxt;
        end
    end

endmodule

// File: rtl/tx_wrr_sched.sv
// WRR scheduler for CCI-P Tx C0/C1 with C1 burst lock; optional stats via TX_SCHED_STATS_EN.
// Latency: request sampled at cycle t yields a registered one-hot grant at t+1.
// Backpressure: almFull stops C0 grants and C1 burst starts; an open C1 burst runs to eop.
module tx_wrr_sched
    import tx_sched_pkg::*;
#(
    parameter int N_SUBAFUS      = 3,
    parameter int WEIGHT_W       = 4,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic          clk,
    input  logic          reset,
    tx_wrr_sched_if.slave bus
);

    localparam int IDX_W = $clog2(N_SUBAFUS);

    logic [N_SUBAFUS*WEIGHT_W-1:0] r_weights;
    logic [N_SUBAFUS-1:0]          r_grant_c0, r_grant_c1;
    logic [N_SUBAFUS-1:0]          w_c0_pick, w_c1_pick, w_c1_grant, w_owner_vec;
    logic [IDX_W-1:0]              w_c0_idx, w_c1_idx, r_owner, w_owner_nxt;
    t_c1_state                     r_state, w_state_nxt;
    logic                          w_c1_hold;

    // Runtime weight table; out-of-range indices are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SUBAFUS; i++)
                r_weights[i*WEIGHT_W +: WEIGHT_W] <= WEIGHT_W'(DEFAULT_WEIGHT);
        end else if (bus.cfg_wr_en && 32'(bus.cfg_idx) < N_SUBAFUS) begin
            r_weights[bus.cfg_idx*WEIGHT_W +: WEIGHT_W] <= bus.cfg_weight;
        end
    end

    tx_wrr_chan #(.N(N_SUBAFUS), .WEIGHT_W(WEIGHT_W)) u_c0 (
        .clk(clk), .rst(reset), .i_req(bus.req_c0), .i_hold(bus.in_c0_almFull),
        .i_weights(r_weights), .o_grant(w_c0_pick), .o_idx(w_c0_idx)
    );

    // During a burst the arbiter is frozen so credit is charged only at the sop pick.
    assign w_c1_hold = (r_state == C1_BURST) || bus.in_c1_almFull;

    tx_wrr_chan #(.N(N_SUBAFUS), .WEIGHT_W(WEIGHT_W)) u_c1 (
        .clk(clk), .rst(reset), .i_req(bus.req_c1), .i_hold(w_c1_hold),
        .i_weights(r_weights), .o_grant(w_c1_pick), .o_idx(w_c1_idx)
    );

    // C1 burst FSM: open on sop-without-eop, lock to owner, close on owner's eop.
    always_comb begin
        w_state_nxt          = r_state;
        w_owner_nxt          = r_owner;
        w_c1_grant           = '0;
        w_owner_vec          = '0;
        w_owner_vec[r_owner] = 1'b1;
        case (r_state)
            C1_IDLE: begin
                w_c1_grant = w_c1_pick;
                if (|w_c1_pick && bus.req_c1_sop[w_c1_idx] && !bus.req_c1_eop[w_c1_idx]) begin
                    w_state_nxt = C1_BURST;
                    w_owner_nxt = w_c1_idx;
                end
            end
            C1_BURST: begin
                if (bus.req_c1[r_owner]) begin
                    w_c1_grant = w_owner_vec;
                    if (bus.req_c1_eop[r_owner]) w_state_nxt = C1_IDLE;
                end
            end
            default: w_state_nxt = C1_IDLE;
        endcase
    end

    // Registered grants and burst state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_c0 <= '0;
            r_grant_c1 <= '0;
            r_state    <= C1_IDLE;
            r_owner    <= '0;
        end else begin
            r_grant_c0 <= w_c0_pick;
            r_grant_c1 <= w_c1_grant;
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    assign bus.grant_c0        = r_grant_c0;
    assign bus.grant_c1        = r_grant_c1;
    assign bus.c1_burst_active = (r_state == C1_BURST);

`ifdef TX_SCHED_STATS_EN
    logic [STAT_W-1:0] r_c0_cnt [N_SUBAFUS];
    logic [STAT_W-1:0] r_c1_cnt [N_SUBAFUS];

    // Saturating per-requester grant counters, fed from the issued grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SUBAFUS; i++) begin
                r_c0_cnt[i] <= '0;
                r_c1_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SUBAFUS; i++) begin
                if (r_grant_c0[i] && r_c0_cnt[i] != '1) r_c0_cnt[i] <= r_c0_cnt[i] + STAT_W'(1);
                if (r_grant_c1[i] && r_c1_cnt[i] != '1) r_c1_cnt[i] <= r_c1_cnt[i] + STAT_W'(1);
            end
        end
    end

    // Combinational counter read; out-of-range index reads zero.
    always_comb begin
        bus.stat_c0_cnt = '0;
        bus.stat_c1_cnt = '0;
        if (32'(bus.stat_idx) < N_SUBAFUS) begin
            bus.stat_c0_cnt = r_c0_cnt[bus.stat_idx];
            bus.stat_c1_cnt = r_c1_cnt[bus.stat_idx];
        end
    end
`endif

endmodule

// File: tb/tb_tx_wrr_sched.sv
// Directed bench for tx_wrr_sched (N=3): RR, weights, almFull, C1 bursts, reset.
// Latency: checks grants 1 ns after the edge that sampled the request.
// Backpressure: exercises both almFull inputs; stat counters when TX_SCHED_STATS_EN is set.
module tb_tx_wrr_sched;

    localparam int N = 3;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tx_wrr_sched_if #(.N_SUBAFUS(N), .WEIGHT_W(W)) bus ();

    tx_wrr_sched #(.N_SUBAFUS(N), .WEIGHT_W(W), .DEFAULT_WEIGHT(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic c1_step(input string tag, input logic [2:0] eg, input logic eb);
        step();
        check({tag, "_gnt"}, 32'(bus.grant_c1), 32'(eg));
        check({tag, "_burst"}, 32'(bus.c1_burst_active), 32'(eb));
    endtask

    logic [2:0] t2_exp [8] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001, 3'b001};
    logic [2:0] w0_exp [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        reset             = 1'b1;
        bus.req_c0        = '0;
        bus.req_c1        = '0;
        bus.req_c1_sop    = '0;
        bus.req_c1_eop    = '0;
        bus.in_c0_almFull = 1'b0;
        bus.in_c1_almFull = 1'b0;
        bus.cfg_wr_en     = 1'b0;
        bus.cfg_idx       = '0;
        bus.cfg_weight    = '0;
`ifdef TX_SCHED_STATS_EN
        bus.stat_idx      = '0;
`endif
        #12;
        check("rst_gnt_c0", 32'(bus.grant_c0), 32'd0);
        check("rst_gnt_c1", 32'(bus.grant_c1), 32'd0);
        check("rst_burst", 32'(bus.c1_burst_active), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Equal weights: plain rotation starting at requester 0.
        bus.req_c0 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t1_rr", 32'(bus.grant_c0), 32'd1 << (i % 3));
        end
`ifdef TX_SCHED_STATS_EN
        for (int i = 6; i < 30; i++) begin
            step();
            check("t1_rr_long", 32'(bus.grant_c0), 32'd1 << (i % 3));
        end
`endif
        bus.req_c0 = 3'b000;
        step();
        check("idle0", 32'(bus.grant_c0), 32'd0);
`ifdef TX_SCHED_STATS_EN
        for (int i = 0; i < N; i++) begin
            bus.stat_idx = 2'(i);
            #1;
            check("stat_c0", bus.stat_c0_cnt, 32'd10);
        end
`endif

        // Invalid index write is dropped; then weight of requester 0 becomes 3.
        bus.cfg_wr_en  = 1'b1;
        bus.cfg_idx    = 2'd3;
        bus.cfg_weight = 4'd7;
        step();
        check("cfg_bad_gnt", 32'(bus.grant_c0), 32'd0);
        bus.cfg_idx    = 2'd0;
        bus.cfg_weight = 4'd3;
        step();
        bus.cfg_wr_en  = 1'b0;

        // Weights {3,1,1}: three back-to-back grants for requester 0.
        bus.req_c0 = 3'b111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_wrr", 32'(bus.grant_c0), 32'(t2_exp[i]));
        end
        bus.req_c0     = 3'b000;
        bus.cfg_wr_en  = 1'b1;
        bus.cfg_idx    = 2'd0;
        bus.cfg_weight = 4'd0;
        step();
        check("idle1", 32'(bus.grant_c0), 32'd0);
        bus.cfg_wr_en  = 1'b0;

        // Weight 0 acts as weight 1.
        bus.req_c0 = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("w0_rr", 32'(bus.grant_c0), 32'(w0_exp[i]));
        end

        // C0 almFull: no grants, pointer frozen at requester 2.
        bus.in_c0_almFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("c0_af", 32'(bus.grant_c0), 32'd0);
        end
        bus.in_c0_almFull = 1'b0;
        step();
        check("c0_af_rel0", 32'(bus.grant_c0), 32'b001);
        step();
        check("c0_af_rel1", 32'(bus.grant_c0), 32'b010);
        bus.req_c0 = 3'b000;

        // C1: single-line write from requester 0 places the pointer at 0.
        bus.req_c1     = 3'b001;
        bus.req_c1_sop = 3'b111;
        bus.req_c1_eop = 3'b111;
        c1_step("c1_1cl", 3'b001, 1'b0);

        // 4-line burst from requester 1 while 0 and 2 also request.
        bus.req_c1     = 3'b111;
        bus.req_c1_eop = 3'b101;
        c1_step("b_sop", 3'b010, 1'b1);
        bus.req_c1_sop = 3'b101;
        c1_step("b_mid1", 3'b010, 1'b1);
        bus.req_c1     = 3'b101;
        c1_step("b_gap", 3'b000, 1'b1);
        bus.req_c1        = 3'b111;
        bus.in_c1_almFull = 1'b1;
        c1_step("b_mid2_af", 3'b010, 1'b1);
        bus.req_c1_eop = 3'b111;
        c1_step("b_eop_af", 3'b010, 1'b0);
        bus.req_c1_sop = 3'b111;
        c1_step("af_block0", 3'b000, 1'b0);
        c1_step("af_block1", 3'b000, 1'b0);
        bus.in_c1_almFull = 1'b0;
        c1_step("af_release", 3'b100, 1'b0);

        // Reset in the middle of a burst from requester 0.
        bus.req_c1     = 3'b001;
        bus.req_c1_sop = 3'b001;
        bus.req_c1_eop = 3'b000;
        c1_step("rb_sop", 3'b001, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rb_gnt", 32'(bus.grant_c1), 32'd0);
        check("rb_burst", 32'(bus.c1_burst_active), 32'd0);
        @(negedge clk);
        reset          = 1'b0;
        bus.req_c1     = 3'b010;
        bus.req_c1_sop = 3'b010;
        bus.req_c1_eop = 3'b010;
        c1_step("rb_after", 3'b010, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
